// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding, one-hot grant
// values, the heartbeat message ROM and the debug view of the arbiter state.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_CH0  = 3'b001;
  localparam logic [2:0] GNT_CH1  = 3'b010;
  localparam logic [2:0] GNT_HB   = 3'b100;

  localparam int unsigned HB_LEN = 6;

  typedef struct packed {
    logic [1:0] state;
    logic [2:0] grant;
    logic       done;
  } arb_dbg_t;

  // Heartbeat packet "test\r\n"
  function automatic logic [7:0] hb_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    hb_byte = 8'h74;
      3'd1:    hb_byte = 8'h65;
      3'd2:    hb_byte = 8'h73;
      3'd3:    hb_byte = 8'h74;
      3'd4:    hb_byte = 8'h0D;
      3'd5:    hb_byte = 8'h0A;
      default: hb_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_arb_rr2.sv
// Combinational two-way round-robin pick. last_grant_i = 1 means ch1 owned the
// UART most recently, so ch0 wins a tie.
module uart_arb_rr2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter between two
// byte streams. Optional heartbeat requester enabled by UART_ARB_HEARTBEAT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 2700000,
  parameter int unsigned HEARTBEAT_PERIOD = 27000000
) (
  input  logic                  system_clk,
  input  logic                  reset_n,
  input  logic                  ch0_valid,
  input  logic [DATA_WIDTH-1:0] ch0_data,
  input  logic                  ch0_last,
  output logic                  ch0_ack,
  input  logic                  ch1_valid,
  input  logic [DATA_WIDTH-1:0] ch1_data,
  input  logic                  ch1_last,
  output logic                  ch1_ack,
  input  logic                  uart_tx_fifo_ready,
  output logic                  start_uart_tx,
  output logic [DATA_WIDTH-1:0] uart_tx_data,
  output logic [2:0]            grant,
  output logic                  timeout_err,
  output arb_dbg_t              dbg_o
);

  localparam int unsigned     TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || HEARTBEAT_PERIOD < 2) begin : g_bad_params
    $error("uart_tx_arbiter: TIMEOUT_CYCLES and HEARTBEAT_PERIOD must be >= 2");
  end

  logic [1:0]            state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  start_q, start_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  tout_q, tout_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [1:0]            rr_pick;
  logic                  hb_req;
  logic [DATA_WIDTH-1:0] hb_data;
  logic                  hb_last;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  uart_arb_rr2 u_rr (
    .valid0_i     (ch0_valid),
    .valid1_i     (ch1_valid),
    .last_grant_i (last_q),
    .grant_o      (rr_pick)
  );

`ifdef UART_ARB_HEARTBEAT_EN
  localparam int unsigned HB_W = $clog2(HEARTBEAT_PERIOD);

  logic [HB_W-1:0] hb_cnt_q;
  logic            hb_pend_q;
  logic [2:0]      hb_idx_q;
  logic            hb_tick;
  logic            hb_take;
  logic            hb_issue;

  assign hb_tick  = (hb_cnt_q == HB_W'(HEARTBEAT_PERIOD - 1));
  assign hb_take  = (state_q == ST_IDLE) && (rr_pick == 2'b00) && hb_pend_q;
  assign hb_issue = (state_q == ST_SEND) && grant_q[2] && uart_tx_fifo_ready;

  // A tick landing while the flag is already set merges into one pending send.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_q  <= '0;
      hb_pend_q <= 1'b0;
      hb_idx_q  <= 3'd0;
    end else begin
      hb_cnt_q <= hb_tick ? '0 : hb_cnt_q + 1'b1;
      if (hb_tick) begin
        hb_pend_q <= 1'b1;
      end else if (hb_take) begin
        hb_pend_q <= 1'b0;
      end
      if (hb_take) begin
        hb_idx_q <= 3'd0;
      end else if (hb_issue) begin
        hb_idx_q <= hb_idx_q + 3'd1;
      end
    end
  end

  assign hb_req  = hb_pend_q;
  assign hb_data = DATA_WIDTH'(hb_byte(hb_idx_q));
  assign hb_last = (hb_idx_q == 3'(HB_LEN - 1));
`else
  assign hb_req  = 1'b0;
  assign hb_data = '0;
  assign hb_last = 1'b0;
`endif

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    if (grant_q[0]) begin
      sel_valid = ch0_valid;
      sel_data  = ch0_data;
      sel_last  = ch0_last;
    end else if (grant_q[1]) begin
      sel_valid = ch1_valid;
      sel_data  = ch1_data;
      sel_last  = ch1_last;
    end else if (grant_q[2]) begin
      sel_valid = 1'b1;
      sel_data  = hb_data;
      sel_last  = hb_last;
    end
  end

  // Handshake: a requester holds valid/data/last stable until its ack pulse;
  // ack, start_uart_tx and the new uart_tx_data all appear in the same cycle.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    done_d   = done_q;
    to_cnt_d = to_cnt_q;
    start_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    tout_d   = 1'b0;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        done_d   = 1'b0;
        to_cnt_d = '0;
        if (rr_pick != 2'b00) begin
          grant_d = {1'b0, rr_pick};
          state_d = ST_SEND;
        end else if (hb_req) begin
          grant_d = GNT_HB;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sel_valid && uart_tx_fifo_ready) begin
          start_d  = 1'b1;
          ack0_d   = grant_q[0];
          ack1_d   = grant_q[1];
          data_d   = sel_data;
          done_d   = sel_last;
          to_cnt_d = '0;
          state_d  = ST_GAP;
        end else if (!grant_q[2]) begin
          // Reaching TO_MAX always revokes, so the counter never wraps.
          if (to_cnt_q == TO_MAX) begin
            tout_d  = 1'b1;
            grant_d = GNT_NONE;
            last_d  = grant_q[1];
            state_d = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (done_q) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          if (!grant_q[2]) begin
            last_d = grant_q[1];
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_NONE;
      last_q   <= 1'b1;
      done_q   <= 1'b0;
      to_cnt_q <= '0;
      start_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      tout_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      done_q   <= done_d;
      to_cnt_q <= to_cnt_d;
      start_q  <= start_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      tout_q   <= tout_d;
      data_q   <= data_d;
    end
  end

  assign ch0_ack       = ack0_q;
  assign ch1_ack       = ack1_q;
  assign start_uart_tx = start_q;
  assign uart_tx_data  = data_q;
  assign grant         = grant_q;
  assign timeout_err   = tout_q;

  assign dbg_o.state = state_q;
  assign dbg_o.grant = grant_q;
  assign dbg_o.done  = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Heartbeat scenarios are included when
// UART_ARB_HEARTBEAT_EN is defined.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int TO = 64;

  logic       system_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ch0_valid = 1'b0, ch0_last = 1'b0, ch1_valid = 1'b0, ch1_last = 1'b0;
  logic [7:0] ch0_data = 8'h00, ch1_data = 8'h00;
  logic       uart_tx_fifo_ready = 1'b1;
  logic       ch0_ack, ch1_ack, start_uart_tx, timeout_err;
  logic [7:0] uart_tx_data;
  logic [2:0] grant;
  arb_dbg_t   dbg;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int n_starts = 0;
  int tout_cnt = 0;
  int tout_cyc = 0;
  int k, r, snap, w, w2;
  logic        prev_start = 1'b0;
  logic [10:0] mon_e;
  logic [10:0] exp_q[$];
  int          start_cyc_q[$];

`ifdef UART_ARB_HEARTBEAT_EN
  logic [7:0] hb_msg [6] = '{8'h74, 8'h65, 8'h73, 8'h74, 8'h0D, 8'h0A};
`endif

  uart_tx_arbiter #(
    .DATA_WIDTH       (8),
    .TIMEOUT_CYCLES   (TO),
    .HEARTBEAT_PERIOD (100)
  ) u_dut (
    .system_clk         (system_clk),
    .reset_n            (reset_n),
    .ch0_valid          (ch0_valid),
    .ch0_data           (ch0_data),
    .ch0_last           (ch0_last),
    .ch0_ack            (ch0_ack),
    .ch1_valid          (ch1_valid),
    .ch1_data           (ch1_data),
    .ch1_last           (ch1_last),
    .ch1_ack            (ch1_ack),
    .uart_tx_fifo_ready (uart_tx_fifo_ready),
    .start_uart_tx      (start_uart_tx),
    .uart_tx_data       (uart_tx_data),
    .grant              (grant),
    .timeout_err        (timeout_err),
    .dbg_o              (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
    if (ch == 0) begin
      ch0_valid = v; ch0_data = d; ch0_last = l;
    end else begin
      ch1_valid = v; ch1_data = d; ch1_last = l;
    end
  endtask

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? ch0_ack : ch1_ack;
  endfunction

  task automatic expect_pkt(input logic [2:0] g, input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({g, bytes[8*i +: 8]});
  endtask

  task automatic send_pkt(input int ch, input logic [31:0] bytes, input int n,
                          input logic end_last, input int max_wait);
    for (int i = 0; i < n; i++) begin
      int cnt;
      cnt = 0;
      set_ch(ch, 1'b1, bytes[8*i +: 8], end_last && (i == n - 1));
      @(negedge system_clk);
      while (!ack_of(ch) && cnt < max_wait) begin
        @(negedge system_clk);
        cnt++;
      end
      check("ack_wait", ack_of(ch), 1);
      tick();
    end
    set_ch(ch, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_ch(0, 1'b0, 8'h00, 1'b0);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    uart_tx_fifo_ready = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge system_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < max_cyc) begin
      tick();
      cnt++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge system_clk) begin
    if (reset_n) begin
      if (start_uart_tx) begin
        n_starts++;
        start_cyc_q.push_back(cyc);
        check("no_back_to_back_start", prev_start, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_start", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("start_grant", grant, mon_e[10:8]);
          check("start_data", uart_tx_data, mon_e[7:0]);
        end
        check("ch0_ack_vs_start", ch0_ack, grant[0]);
        check("ch1_ack_vs_start", ch1_ack, grant[1]);
      end else if (ch0_ack || ch1_ack) begin
        check("ack_without_start", {ch0_ack, ch1_ack}, 0);
      end
      if (timeout_err) begin
        tout_cnt++;
        tout_cyc = cyc;
        check("grant_clear_on_timeout", grant, 0);
      end
    end
    prev_start = start_uart_tx;
  end

  // ---------------- directed tests ----------------
  initial begin
    // reset values
    #2;
    check("rst_start", start_uart_tx, 0);
    check("rst_ack0", ch0_ack, 0);
    check("rst_ack1", ch1_ack, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_grant", grant, 0);
    check("rst_data", uart_tx_data, 0);
    check("rst_state", dbg.state, ST_IDLE);

    // T1: ch0 three-byte packet, starts at +2,+4,+6, grant 001 on +1..+6
    do_reset();
    expect_pkt(GNT_CH0, 32'h00434241, 3);
    start_cyc_q.delete();
    k = cyc;
    fork
      send_pkt(0, 32'h00434241, 3, 1'b1, 20);
      begin
        for (int j = 0; j <= 7; j++) begin
          @(negedge system_clk);
          check("t1_grant", grant, (j >= 1 && j <= 6) ? 3'b001 : 3'b000);
        end
      end
    join
    check("t1_start_count", start_cyc_q.size(), 3);
    if (start_cyc_q.size() >= 3) begin
      check("t1_start0_cycle", start_cyc_q[0] - k, 2);
      check("t1_start1_cycle", start_cyc_q[1] - k, 4);
      check("t1_start2_cycle", start_cyc_q[2] - k, 6);
    end
    drain("t1_drain", 20);

    // T2: both channels with two 2-byte packets each -> ch0, ch1, ch0, ch1
    do_reset();
    expect_pkt(GNT_CH0, 32'h0000A1A0, 2);
    expect_pkt(GNT_CH1, 32'h0000B1B0, 2);
    expect_pkt(GNT_CH0, 32'h0000C1C0, 2);
    expect_pkt(GNT_CH1, 32'h0000D1D0, 2);
    fork
      begin
        send_pkt(0, 32'h0000A1A0, 2, 1'b1, 40);
        send_pkt(0, 32'h0000C1C0, 2, 1'b1, 40);
      end
      begin
        send_pkt(1, 32'h0000B1B0, 2, 1'b1, 40);
        send_pkt(1, 32'h0000D1D0, 2, 1'b1, 40);
      end
    join
    drain("t2_drain", 20);

    // T3: ch1 stalled by fifo_ready=0 for 50 cycles; ch0 waits unacked
    do_reset();
    expect_pkt(GNT_CH1, 32'h00535251, 3);
    expect_pkt(GNT_CH0, 32'h00000060, 1);
    fork
      send_pkt(1, 32'h00535251, 3, 1'b1, 200);
      begin
        w = 0;
        @(negedge system_clk);
        while (!ch1_ack && w < 20) begin
          @(negedge system_clk);
          w++;
        end
        check("t3_first_ack", ch1_ack, 1);
        tick();
        uart_tx_fifo_ready = 1'b0;
        snap = n_starts;
        repeat (50) tick();
        check("t3_no_start_in_stall", n_starts, snap);
        uart_tx_fifo_ready = 1'b1;
        r = cyc;
        w2 = 0;
        @(negedge system_clk);
        while (!start_uart_tx && w2 < 10) begin
          @(negedge system_clk);
          w2++;
        end
        check("t3_resume_latency", cyc - r, 1);
      end
      begin
        repeat (3) tick();
        send_pkt(0, 32'h00000060, 1, 1'b1, 300);
      end
    join
    drain("t3_drain", 20);

    // T4: ch0 non-last byte then drops valid -> timeout, then waiting ch1
    do_reset();
    expect_pkt(GNT_CH0, 32'h00000070, 1);
    expect_pkt(GNT_CH1, 32'h00008281, 2);
    start_cyc_q.delete();
    tout_cnt = 0;
    fork
      send_pkt(0, 32'h00000070, 1, 1'b0, 20);
      begin
        repeat (4) tick();
        send_pkt(1, 32'h00008281, 2, 1'b1, 200);
      end
    join
    drain("t4_drain", 20);
    check("t4_timeout_pulses", tout_cnt, 1);
    check("t4_start_count", start_cyc_q.size(), 3);
    if (start_cyc_q.size() >= 2) begin
      check("t4_timeout_latency", tout_cyc - start_cyc_q[0], TO + 1);
      check("t4_ch1_after_timeout", start_cyc_q[1] - tout_cyc, 2);
    end

    // T5: asynchronous reset mid-packet, then ch1 proceeds normally
    do_reset();
    expect_pkt(GNT_CH0, 32'h00000090, 1);
    set_ch(0, 1'b1, 8'h90, 1'b0);
    w = 0;
    @(negedge system_clk);
    while (!ch0_ack && w < 10) begin
      @(negedge system_clk);
      w++;
    end
    check("t5_ack_before_reset", ch0_ack, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_start", start_uart_tx, 0);
    check("t5_async_ack0", ch0_ack, 0);
    check("t5_async_grant", grant, 0);
    check("t5_async_data", uart_tx_data, 0);
    check("t5_async_timeout", timeout_err, 0);
    check("t5_async_state", dbg.state, ST_IDLE);
    set_ch(0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge system_clk);
    #1;
    reset_n = 1'b1;
    check("t5_queue_drained", exp_q.size(), 0);
    expect_pkt(GNT_CH1, 32'h0000B2B1, 2);
    start_cyc_q.delete();
    k = cyc;
    send_pkt(1, 32'h0000B2B1, 2, 1'b1, 20);
    if (start_cyc_q.size() >= 1) check("t5_first_latency", start_cyc_q[0] - k, 2);
    drain("t5_drain", 20);

`ifdef UART_ARB_HEARTBEAT_EN
    // T6a: idle channels -> heartbeat packet under grant 100
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back({GNT_HB, hb_msg[i]});
    drain("t6_hb_idle", 300);

    // T6b: ch0 busy when the heartbeat becomes pending -> ch0 first
    do_reset();
    repeat (95) tick();
    expect_pkt(GNT_CH0, 32'h00E2E1E0, 3);
    for (int i = 0; i < 6; i++) exp_q.push_back({GNT_HB, hb_msg[i]});
    send_pkt(0, 32'h00E2E1E0, 3, 1'b1, 20);
    drain("t6_hb_after_ch0", 200);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    total++;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
